// File: rtl/regpair_seq.sv
// Sequencer for 16-bit register-pair updates on a byte-write register file:
// one pair read, then two byte writes in a fixed order, then a done pulse.
module regpair_seq #(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_pair,
  input  logic [15:0] cmd_data,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_h,
  output logic        flag_c,
  output logic [1:0]  rf_rdwn,
  input  logic [15:0] rf_rdw,
  output logic [2:0]  rf_wrn,
  output logic [7:0]  rf_wr,
  output logic        rf_we
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WR1  = 3'd2;
  localparam logic [2:0] S_WR2  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_LD16  = 2'd0;
  localparam logic [1:0] OP_INC16 = 2'd1;
  localparam logic [1:0] OP_DEC16 = 2'd2;
  localparam logic [1:0] OP_ADD8S = 2'd3;

  logic [2:0]  state;
  logic [1:0]  op_q;
  logic [15:0] data_q;
  logic [15:0] val_q;
  logic        h_q;
  logic        c_q;

  logic [15:0] calc_val;
  logic        calc_h;
  logic        calc_c;
  logic [4:0]  nib_sum;
  logic [8:0]  byte_sum;
  logic        write_hi;

  // New pair value and low-byte carries, evaluated against the pair read in READ.
  always_comb begin
    nib_sum  = {1'b0, rf_rdw[3:0]} + {1'b0, data_q[3:0]};
    byte_sum = {1'b0, rf_rdw[7:0]} + {1'b0, data_q[7:0]};
    calc_val = data_q;
    calc_h   = 1'b0;
    calc_c   = 1'b0;
    case (op_q)
      OP_LD16:  calc_val = data_q;
      OP_INC16: calc_val = rf_rdw + 16'd1;
      OP_DEC16: calc_val = rf_rdw - 16'd1;
      OP_ADD8S: begin
        calc_val = rf_rdw + {{8{data_q[7]}}, data_q[7:0]};
        calc_h   = nib_sum[4];
        calc_c   = byte_sum[8];
      end
      default:  calc_val = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rf_rdwn <= '0;
      val_q   <= '0;
      h_q     <= 1'b0;
      c_q     <= 1'b0;
      result  <= '0;
      flag_h  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            rf_rdwn <= cmd_pair;
            state   <= S_READ;
          end
        end
        S_READ: begin
          val_q <= calc_val;
          h_q   <= calc_h;
          c_q   <= calc_c;
          state <= S_WR1;
        end
        S_WR1: state <= S_WR2;
        S_WR2: begin
          // Published results stay stable until the next command completes.
          result <= val_q;
          flag_h <= h_q;
          flag_c <= c_q;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write port decodes only from state and latched registers.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    done      = (state == S_DONE);
    rf_we     = 1'b0;
    rf_wrn    = '0;
    rf_wr     = '0;
    write_hi  = HI_FIRST;
    if (state == S_WR1 || state == S_WR2) begin
      write_hi = (state == S_WR1) ? HI_FIRST : !HI_FIRST;
      rf_we    = 1'b1;
      rf_wrn   = {rf_rdwn, !write_hi};
      rf_wr    = write_hi ? val_q[15:8] : val_q[7:0];
    end
  end

endmodule

// File: tb/tb_regpair_seq.sv
// Bench for regpair_seq: both byte orders side by side, each on its own
// byte-wide register file, checked against a pair-level arithmetic model.
module tb_regpair_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [1:0]  cmd_pair = '0;
  logic [15:0] cmd_data = '0;

  logic        ready0, done0, fh0, fc0, we0;
  logic [15:0] result0, rdw0;
  logic [1:0]  rdwn0;
  logic [2:0]  wrn0;
  logic [7:0]  wr0;

  logic        ready1, done1, fh1, fc1, we1;
  logic [15:0] result1, rdw1;
  logic [1:0]  rdwn1;
  logic [2:0]  wrn1;
  logic [7:0]  wr1;

  logic [7:0]  rf0 [0:7] = '{default: 8'h00};
  logic [7:0]  rf1 [0:7] = '{default: 8'h00};
  logic [15:0] mdl [0:3] = '{default: 16'h0000};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regpair_seq #(.HI_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready0),
    .cmd_op(cmd_op), .cmd_pair(cmd_pair), .cmd_data(cmd_data),
    .done(done0), .result(result0), .flag_h(fh0), .flag_c(fc0),
    .rf_rdwn(rdwn0), .rf_rdw(rdw0), .rf_wrn(wrn0), .rf_wr(wr0), .rf_we(we0)
  );

  regpair_seq #(.HI_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready1),
    .cmd_op(cmd_op), .cmd_pair(cmd_pair), .cmd_data(cmd_data),
    .done(done1), .result(result1), .flag_h(fh1), .flag_c(fc1),
    .rf_rdwn(rdwn1), .rf_rdw(rdw1), .rf_wrn(wrn1), .rf_wr(wr1), .rf_we(we1)
  );

  assign rdw0 = {rf0[{rdwn0, 1'b0}], rf0[{rdwn0, 1'b1}]};
  assign rdw1 = {rf1[{rdwn1, 1'b0}], rf1[{rdwn1, 1'b1}]};

  always @(posedge clk) begin
    if (we0) rf0[wrn0] <= wr0;
    if (we1) rf1[wrn1] <= wr1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pair-level reference: plain integer arithmetic on the 16-bit pair value.
  function automatic void ref_op(input logic [1:0] op, input logic [15:0] v,
                                 input logic [15:0] d, output logic [15:0] r,
                                 output bit h, output bit c);
    int vi, d8, sd;
    vi = v;
    d8 = d[7:0];
    sd = (d8 >= 128) ? d8 - 256 : d8;
    h  = 1'b0;
    c  = 1'b0;
    case (op)
      2'd0: r = d;
      2'd1: r = 16'((vi + 1) % 65536);
      2'd2: r = 16'((vi + 65535) % 65536);
      default: begin
        r = 16'((vi + sd + 65536) % 65536);
        h = ((vi % 16) + (d8 % 16)) >= 16;
        c = ((vi % 256) + d8) >= 256;
      end
    endcase
  endfunction

  task automatic scramble();
    cmd_op   = 2'($urandom);
    cmd_pair = 2'($urandom);
    cmd_data = 16'($urandom);
  endtask

  // Called at a falling edge with both DUTs idle; returns at the falling edge
  // of the following IDLE cycle (T0+5).
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] pair,
                        input logic [15:0] data, input bit keep,
                        input logic [15:0] er, input bit eh, input bit ec);
    logic [2:0] hi_idx, lo_idx;
    hi_idx = {pair, 1'b0};
    lo_idx = {pair, 1'b1};
    chk({tag, " ready0 idle"}, 32'(ready0), 32'd1);
    chk({tag, " ready1 idle"}, 32'(ready1), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_pair  = pair;
    cmd_data  = data;
    @(negedge clk); // READ
    if (!keep) cmd_valid = 1'b0;
    scramble();
    chk({tag, " ready0 read"}, 32'(ready0), 32'd0);
    chk({tag, " we0 read"}, 32'(we0), 32'd0);
    chk({tag, " rdwn0 read"}, 32'(rdwn0), 32'(pair));
    chk({tag, " rdwn1 read"}, 32'(rdwn1), 32'(pair));
    @(negedge clk); // WR1
    scramble();
    chk({tag, " ready0 wr1"}, 32'(ready0), 32'd0);
    chk({tag, " we0 wr1"}, 32'(we0), 32'd1);
    chk({tag, " wrn0 wr1"}, 32'(wrn0), 32'(lo_idx));
    chk({tag, " wr0 wr1"}, 32'(wr0), 32'(er[7:0]));
    chk({tag, " we1 wr1"}, 32'(we1), 32'd1);
    chk({tag, " wrn1 wr1"}, 32'(wrn1), 32'(hi_idx));
    chk({tag, " wr1 wr1"}, 32'(wr1), 32'(er[15:8]));
    @(negedge clk); // WR2
    scramble();
    chk({tag, " ready0 wr2"}, 32'(ready0), 32'd0);
    chk({tag, " we0 wr2"}, 32'(we0), 32'd1);
    chk({tag, " wrn0 wr2"}, 32'(wrn0), 32'(hi_idx));
    chk({tag, " wr0 wr2"}, 32'(wr0), 32'(er[15:8]));
    chk({tag, " wrn1 wr2"}, 32'(wrn1), 32'(lo_idx));
    chk({tag, " wr1 wr2"}, 32'(wr1), 32'(er[7:0]));
    chk({tag, " done0 early"}, 32'(done0), 32'd0);
    @(negedge clk); // DONE
    scramble();
    chk({tag, " done0"}, 32'(done0), 32'd1);
    chk({tag, " done1"}, 32'(done1), 32'd1);
    chk({tag, " ready0 done"}, 32'(ready0), 32'd0);
    chk({tag, " we0 done"}, 32'(we0), 32'd0);
    chk({tag, " result0"}, 32'(result0), 32'(er));
    chk({tag, " result1"}, 32'(result1), 32'(er));
    chk({tag, " flag_h"}, 32'(fh0), 32'(eh));
    chk({tag, " flag_c"}, 32'(fc0), 32'(ec));
    chk({tag, " flags1"}, 32'({fh1, fc1}), 32'({eh, ec}));
    chk({tag, " rf0 pair"}, 32'({rf0[hi_idx], rf0[lo_idx]}), 32'(er));
    chk({tag, " rf1 pair"}, 32'({rf1[hi_idx], rf1[lo_idx]}), 32'(er));
    mdl[pair] = er;
    @(negedge clk); // IDLE
    chk({tag, " done0 after"}, 32'(done0), 32'd0);
    chk({tag, " result0 held"}, 32'(result0), 32'(er));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  pair;
    logic [15:0] data;
    bit          keep;
    logic [15:0] r;
    bit          h;
    bit          c;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [15:0] er;
    bit eh, ec;
    logic [1:0] op, pr;
    logic [15:0] d;

    tbl[0]  = '{2'd0, 2'd1, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[1]  = '{2'd0, 2'd2, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[2]  = '{2'd1, 2'd2, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{2'd2, 2'd2, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[4]  = '{2'd0, 2'd3, 16'h00FF, 1'b0, 16'h00FF, 1'b0, 1'b0};
    tbl[5]  = '{2'd3, 2'd3, 16'h7701, 1'b0, 16'h0100, 1'b1, 1'b1};
    tbl[6]  = '{2'd0, 2'd3, 16'h1000, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[7]  = '{2'd3, 2'd3, 16'h00FF, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    tbl[8]  = '{2'd0, 2'd0, 16'hABCD, 1'b0, 16'hABCD, 1'b0, 1'b0};
    tbl[9]  = '{2'd0, 2'd0, 16'h00FE, 1'b0, 16'h00FE, 1'b0, 1'b0};
    tbl[10] = '{2'd1, 2'd0, 16'h0000, 1'b1, 16'h00FF, 1'b0, 1'b0};
    tbl[11] = '{2'd1, 2'd0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b0};

    @(negedge clk);
    chk("rst ready", 32'(ready0), 32'd1);
    chk("rst done", 32'(done0), 32'd0);
    chk("rst result", 32'(result0), 32'd0);
    chk("rst flags", 32'({fh0, fc0}), 32'd0);
    chk("rst rdwn", 32'(rdwn0), 32'd0);
    chk("rst wr port", 32'({we0, wrn0, wr0}), 32'd0);
    chk("rst result1", 32'(result1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      do_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].pair, tbl[i].data,
             tbl[i].keep, tbl[i].r, tbl[i].h, tbl[i].c);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      pr = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      ref_op(op, mdl[pr], d, er, eh, ec);
      do_cmd($sformatf("rnd%0d", i), op, pr, d, 1'($urandom), er, eh, ec);
    end

    // Abort an LD16 in WR1: no writes may land and no done may appear.
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_pair  = 2'd1;
    cmd_data  = ~mdl[1];
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort we0 before", 32'(we0), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort we0 async", 32'(we0), 32'd0);
    chk("abort we1 async", 32'(we1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort done0 c%0d", k), 32'(done0), 32'd0);
      chk($sformatf("abort we0 c%0d", k), 32'(we0), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready0", 32'(ready0), 32'd1);
    chk("abort ready1", 32'(ready1), 32'd1);
    chk("abort done0", 32'(done0), 32'd0);
    chk("abort result0", 32'(result0), 32'd0);
    chk("abort rf0 DE", 32'({rf0[2], rf0[3]}), 32'(mdl[1]));
    chk("abort rf1 DE", 32'({rf1[2], rf1[3]}), 32'(mdl[1]));

    ref_op(2'd3, mdl[1], 16'h0080, er, eh, ec);
    do_cmd("post", 2'd3, 2'd1, 16'h0080, 1'b0, er, eh, ec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
